// File: rtl/seg7_pwm_driver.sv
// seg7_pwm_driver: shadow-buffered 7-segment output stage with PWM dimming, blink and polarity.
// Latency: seg_load to seg_out in the cycle after the next frame boundary; seg_out is registered.
// No backpressure: seg_load is always accepted; optional fade-in is enabled by defining SEG7_FADE_EN.
module seg7_pwm_driver #(
  parameter int unsigned PWM_BITS     = 4,
  parameter logic [23:0] BLINK_DIV    = 24'd5_000_000,
  parameter bit          COMMON_ANODE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [6:0]          seg_in,
  input  logic                dp_in,
  input  logic                seg_load,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blink_en,
  output logic [7:0]          seg_out,
  output logic                frame_start
);

  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [7:0]          POL_MASK   = COMMON_ANODE ? 8'hFF : 8'h00;
  localparam logic [23:0]         BLINK_LAST = BLINK_DIV - 24'd1;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0]          shadow_q, shadow_d;
  logic [7:0]          active_q, active_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [23:0]         blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                frame_start_q;
  logic [7:0]          seg_out_q, seg_out_d;
  logic                fb;
  logic                pwm_on;
  logic [PWM_BITS-1:0] gate_level;

`ifdef SEG7_FADE_EN
  logic [PWM_BITS-1:0] eff_bright_q, eff_bright_d;
`endif

  // Next-state for frame counter, shadow/active pattern, brightness and blink timer
  always_comb begin
    fb            = ena && (pwm_cnt_q == PWM_MAX);
    pwm_cnt_d     = ena ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    // shadow_d already folds in a same-cycle load, which gives the bypass on commit
    shadow_d      = seg_load ? {dp_in, seg_in} : shadow_q;
    active_d      = fb ? shadow_d : active_q;
    bright_d      = fb ? brightness : bright_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!blink_en) begin
      blink_cnt_d   = 24'd0;
      blink_phase_d = 1'b0;
    end else if (ena) begin
      if (blink_cnt_q >= BLINK_LAST) begin
        blink_cnt_d   = 24'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 24'd1;
      end
    end
  end

`ifdef SEG7_FADE_EN
  // Fade-in level: restart at zero on a changed pattern, else step toward the programmed brightness
  always_comb begin
    eff_bright_d = eff_bright_q;
    if (fb) begin
      if (active_d != active_q) begin
        eff_bright_d = '0;
      end else if (bright_d < eff_bright_q) begin
        eff_bright_d = bright_d;
      end else if (eff_bright_q < bright_d) begin
        eff_bright_d = eff_bright_q + 1'b1;
      end
    end
  end

  // Fade level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_bright_q <= '0;
    end else begin
      eff_bright_q <= eff_bright_d;
    end
  end
`endif

  // Output gate evaluated on the values the registers take this edge, so seg_out tracks the new pwm_cnt
  always_comb begin
`ifdef SEG7_FADE_EN
    gate_level = eff_bright_d;
`else
    gate_level = bright_d;
`endif
    pwm_on    = (gate_level == PWM_MAX) || (pwm_cnt_d < gate_level);
    seg_out_d = ((pwm_on && !blink_phase_d && ena) ? active_d : 8'h00) ^ POL_MASK;
  end

  // State and registered outputs; reset blanks the pins immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q     <= '0;
      shadow_q      <= 8'h00;
      active_q      <= 8'h00;
      bright_q      <= '0;
      blink_cnt_q   <= 24'd0;
      blink_phase_q <= 1'b0;
      frame_start_q <= 1'b0;
      seg_out_q     <= POL_MASK;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      bright_q      <= bright_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_start_q <= fb;
      seg_out_q     <= seg_out_d;
    end
  end

  assign seg_out     = seg_out_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_pwm_driver.sv
// Directed bench for seg7_pwm_driver: reset, commit timing, bypass, duty, ena, blink, optional fade.
// Inputs are driven 1ns after the rising edge; outputs are sampled at the same point.
// Every wait on the DUT is bounded and a timeout counts as a miscompare.
module tb_seg7_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [6:0] seg_in;
  logic       dp_in;
  logic       seg_load;
  logic [3:0] brightness;
  logic       blink_en;
  logic [7:0] seg_out;
  logic       frame_start;

  int vectors = 0;
  int errors  = 0;

  seg7_pwm_driver #(
    .PWM_BITS    (4),
    .BLINK_DIV   (24'd8),
    .COMMON_ANODE(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .seg_load   (seg_load),
    .brightness (brightness),
    .blink_en   (blink_en),
    .seg_out    (seg_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next frame_start pulse (pwm_cnt == 0 afterwards)
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    if (frame_start !== 1'b1) begin
      vectors++;
      errors++;
      $display("FAIL wait_frame: no frame_start within %0d cycles", n);
    end
  endtask

  task automatic load(input logic [6:0] pat);
    seg_in   = pat;
    dp_in    = 1'b0;
    seg_load = 1'b1;
    tick();
    seg_load = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n      = 1'b0;
    ena        = 1'b1;
    seg_in     = 7'h00;
    dp_in      = 1'b0;
    seg_load   = 1'b0;
    brightness = 4'd0;
    blink_en   = 1'b0;
    repeat (3) tick();
    vectors++;
    if (seg_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_seg_out: got %h expected 00", seg_out);
    end
    vectors++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_start: got %b expected 0", frame_start);
    end
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    vectors++;
    if (n !== 16) begin
      errors++;
      $display("FAIL first_frame_start: got %0d cycles expected 16", n);
    end
    brightness = 4'd15;
    load(7'h49);
`ifdef SEG7_FADE_EN
    repeat (15) wait_frame();
`endif
    wait_frame();
    vectors++;
    if (seg_out !== 8'h49) begin
      errors++;
      $display("FAIL pre_reset_visible: got %h expected 49", seg_out);
    end
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (seg_out !== 8'h00 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got seg_out=%h frame_start=%b expected 00/0", seg_out, frame_start);
    end
    tick();
    rst_n = 1'b1;
    wait_frame();
    vectors++;
    if (seg_out !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_cleared: got %h expected 00", seg_out);
    end
  endtask

  task automatic test_commit();
    load(7'h49);
    wait_frame();
    vectors++;
    if (seg_out !== 8'h49) begin
      errors++;
      $display("FAIL commit_old: got %h expected 49", seg_out);
    end
    repeat (5) tick();
    seg_in   = 7'h3F;
    seg_load = 1'b1;
    tick();
    seg_load = 1'b0;
    for (int i = 6; i < 16; i++) begin
      vectors++;
      if (seg_out !== 8'h49) begin
        errors++;
        $display("FAIL commit_hold pwm=%0d: got %h expected 49", i, seg_out);
      end
      tick();
    end
    vectors++;
    if (seg_out !== 8'h3F || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL commit_new: got seg_out=%h frame_start=%b expected 3f/1", seg_out, frame_start);
    end
  endtask

  task automatic test_bypass();
    repeat (15) tick();
    seg_in   = 7'h06;
    seg_load = 1'b1;
    tick();
    seg_load = 1'b0;
    vectors++;
    if (seg_out !== 8'h06 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL bypass: got seg_out=%h frame_start=%b expected 06/1", seg_out, frame_start);
    end
  endtask

  task automatic test_duty();
    logic [7:0] exp;
    brightness = 4'd4;
    load(7'h7F);
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      exp = (i < 4) ? 8'h7F : 8'h00;
      vectors++;
      if (seg_out !== exp) begin
        errors++;
        $display("FAIL duty4 pwm=%0d: got %h expected %h", i, seg_out, exp);
      end
      tick();
    end
    brightness = 4'd0;
    wait_frame();
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (seg_out !== 8'h00) begin
        errors++;
        $display("FAIL duty0 pwm=%0d: got %h expected 00", i, seg_out);
      end
      tick();
    end
  endtask

  task automatic test_ena();
    int n;
    brightness = 4'd15;
    load(7'h5B);
    wait_frame();
    vectors++;
    if (seg_out !== 8'h5B) begin
      errors++;
      $display("FAIL ena_pre: got %h expected 5b", seg_out);
    end
    repeat (3) tick();
    ena      = 1'b0;
    seg_in   = 7'h66;
    seg_load = 1'b1;
    tick();
    seg_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (seg_out !== 8'h00 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL ena_low cyc=%0d: got seg_out=%h frame_start=%b expected 00/0", i, seg_out, frame_start);
      end
      tick();
    end
    ena = 1'b1;
    tick();
    vectors++;
    if (seg_out !== 8'h5B) begin
      errors++;
      $display("FAIL ena_resume: got %h expected 5b", seg_out);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    vectors++;
    if (n !== 12) begin
      errors++;
      $display("FAIL ena_hold_count: got %0d cycles to frame_start expected 12", n);
    end
    vectors++;
    if (seg_out !== 8'h66) begin
      errors++;
      $display("FAIL ena_shadow_capture: got %h expected 66", seg_out);
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    blink_en = 1'b1;
    for (int k = 0; k < 28; k++) begin
      tick();
      exp = (((k + 1) / 8) % 2 == 1) ? 8'h00 : 8'h66;
      vectors++;
      if (seg_out !== exp) begin
        errors++;
        $display("FAIL blink k=%0d: got %h expected %h", k, seg_out, exp);
      end
    end
    blink_en = 1'b0;
    tick();
    vectors++;
    if (seg_out !== 8'h66) begin
      errors++;
      $display("FAIL blink_off: got %h expected 66", seg_out);
    end
  endtask

`ifdef SEG7_FADE_EN
  task automatic test_fade();
    int exp_duty [5] = '{0, 1, 2, 3, 3};
    int cnt;
    brightness = 4'd3;
    load(7'h4F);
    wait_frame();
    for (int f = 0; f < 5; f++) begin
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (seg_out === 8'h4F) cnt++;
        tick();
      end
      vectors++;
      if (cnt !== exp_duty[f]) begin
        errors++;
        $display("FAIL fade frame=%0d: got %0d on-cycles expected %0d", f, cnt, exp_duty[f]);
      end
    end
    load(7'h4F);
    wait_frame();
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (seg_out === 8'h4F) cnt++;
        tick();
      end
      vectors++;
      if (cnt !== 3) begin
        errors++;
        $display("FAIL fade_reload frame=%0d: got %0d on-cycles expected 3", f, cnt);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SEG7_FADE_EN
    test_fade();
`else
    test_commit();
    test_bypass();
    test_duty();
    test_ena();
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
